ex_operand_stage: RTL

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage_pkg.sv | 21 ++
 rtl/ex_operand_stage_fwd_mux.sv | 40 ++++
 rtl/ex_operand_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared types and defaults for the EX operand stage: ALU op encodings,
// width defaults and forward-source select.
package ex_operand_stage_pkg;

    localparam int unsigned AW_DEF = 2;
    localparam int unsigned DW_DEF = 8;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_SLT  = 2'b10,
        ALU_SHL4 = 2'b11
    } alu_con_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding mux for one source operand: the newest in-flight producer wins,
// and r0 is never forwarded.
module ex_operand_stage_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic [AW-1:0] src_addr,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_regwrite,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_addr)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_addr)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_data;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand
// forwarding feeding the ALU and the EX/MEM stage.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alusrc,
    input  logic [1:0]    id_alucon,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [1:0]    alu_con,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_store_data,
    output logic          stall
);

    logic          pr_valid_q,    pr_valid_d;
    logic [AW-1:0] pr_rs_q,       pr_rs_d;
    logic [AW-1:0] pr_rt_q,       pr_rt_d;
    logic [AW-1:0] pr_rd_q,       pr_rd_d;
    logic [DW-1:0] pr_rs_data_q,  pr_rs_data_d;
    logic [DW-1:0] pr_rt_data_q,  pr_rt_data_d;
    logic [DW-1:0] pr_imm_q,      pr_imm_d;
    logic          pr_alusrc_q,   pr_alusrc_d;
    alu_con_e      pr_alucon_q,   pr_alucon_d;
    logic          pr_regwrite_q, pr_regwrite_d;
    logic          pr_memread_q,  pr_memread_d;
    logic          pr_memwrite_q, pr_memwrite_d;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        stall = rst_n & pr_valid_q & pr_memread_q & (pr_rd_q != '0) & id_valid &
                ((pr_rd_q == id_rs) |
                 ((pr_rd_q == id_rt) & (~id_alusrc | id_memwrite)));
    end

    always_comb begin
        pr_valid_d    = id_valid;
        pr_rs_d       = id_rs;
        pr_rt_d       = id_rt;
        pr_rd_d       = id_rd;
        pr_rs_data_d  = id_rs_data;
        pr_rt_data_d  = id_rt_data;
        pr_imm_d      = id_imm;
        pr_alusrc_d   = id_alusrc;
        pr_alucon_d   = alu_con_e'(id_alucon);
        pr_regwrite_d = id_regwrite;
        pr_memread_d  = id_memread;
        pr_memwrite_d = id_memwrite;
        if (stall || flush) begin
            pr_valid_d    = 1'b0;
            pr_rs_d       = '0;
            pr_rt_d       = '0;
            pr_rd_d       = '0;
            pr_rs_data_d  = '0;
            pr_rt_data_d  = '0;
            pr_imm_d      = '0;
            pr_alusrc_d   = 1'b0;
            pr_alucon_d   = ALU_ADD;
            pr_regwrite_d = 1'b0;
            pr_memread_d  = 1'b0;
            pr_memwrite_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pr_valid_q    <= 1'b0;
            pr_rs_q       <= '0;
            pr_rt_q       <= '0;
            pr_rd_q       <= '0;
            pr_rs_data_q  <= '0;
            pr_rt_data_q  <= '0;
            pr_imm_q      <= '0;
            pr_alusrc_q   <= 1'b0;
            pr_alucon_q   <= ALU_ADD;
            pr_regwrite_q <= 1'b0;
            pr_memread_q  <= 1'b0;
            pr_memwrite_q <= 1'b0;
        end else begin
            pr_valid_q    <= pr_valid_d;
            pr_rs_q       <= pr_rs_d;
            pr_rt_q       <= pr_rt_d;
            pr_rd_q       <= pr_rd_d;
            pr_rs_data_q  <= pr_rs_data_d;
            pr_rt_data_q  <= pr_rt_data_d;
            pr_imm_q      <= pr_imm_d;
            pr_alusrc_q   <= pr_alusrc_d;
            pr_alucon_q   <= pr_alucon_d;
            pr_regwrite_q <= pr_regwrite_d;
            pr_memread_q  <= pr_memread_d;
            pr_memwrite_q <= pr_memwrite_d;
        end
    end

    ex_operand_stage_fwd_mux #(.AW(AW), .DW(DW)) u_fwd_rs (
        .src_addr       (pr_rs_q),
        .reg_data       (pr_rs_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .fwd_data       (fwd_rs)
    );

    ex_operand_stage_fwd_mux #(.AW(AW), .DW(DW)) u_fwd_rt (
        .src_addr       (pr_rt_q),
        .reg_data       (pr_rt_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .fwd_data       (fwd_rt)
    );

    // Operands come straight off the pipeline register plus forwarding.
    always_comb begin
        alu_con       = pr_alucon_q;
        alu_a         = fwd_rs;
        alu_b         = pr_alusrc_q ? pr_imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        ex_valid      = pr_valid_q;
        ex_regwrite   = pr_valid_q & pr_regwrite_q;
        ex_memread    = pr_valid_q & pr_memread_q;
        ex_memwrite   = pr_valid_q & pr_memwrite_q;
        ex_rd         = pr_valid_q ? pr_rd_q : '0;
    end

endmodule
